// File: rtl/alu_cond_pkg.sv
// Shared types and helpers for the ALU condition unit.
// Holds the ARM condition-code enumeration, the NZCV flag bit positions and
// the condition evaluation function used by alu_cond_eval.
package alu_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Returns 1 when the condition holds for the given NZCV flags.
  // NV is deliberately executed like AL rather than treated as "never".
  function automatic logic cond_eval(input cond_e cond, input logic [3:0] flags);
    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic pass_s;
    n_s = flags[FLAG_N];
    z_s = flags[FLAG_Z];
    c_s = flags[FLAG_C];
    v_s = flags[FLAG_V];
    case (cond)
      EQ:      pass_s = z_s;
      NE:      pass_s = ~z_s;
      CS:      pass_s = c_s;
      CC:      pass_s = ~c_s;
      MI:      pass_s = n_s;
      PL:      pass_s = ~n_s;
      VS:      pass_s = v_s;
      VC:      pass_s = ~v_s;
      HI:      pass_s = c_s & ~z_s;
      LS:      pass_s = ~c_s | z_s;
      GE:      pass_s = (n_s == v_s);
      LT:      pass_s = (n_s != v_s);
      GT:      pass_s = ~z_s & (n_s == v_s);
      LE:      pass_s = z_s | (n_s != v_s);
      AL:      pass_s = 1'b1;
      NV:      pass_s = 1'b1;
      default: pass_s = 1'b1;
    endcase
    return pass_s;
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Purely combinational ARM condition-code table.
// Maps a 4-bit condition code and the current NZCV flags to execute/suppress.
module alu_cond_eval
  import alu_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  // Evaluate the condition against the supplied flags.
  always_comb begin
    cond_ex = cond_eval(cond_e'(cond), flags);
  end

endmodule

// File: rtl/alu_cond_unit.sv
// ALU result/flag consumer: valid/ready intake, architectural NZCV flag
// register, condition evaluation against the pre-update flags and a
// one-entry output register toward register-file write-back.
// Optional feature macro: ALU_COND_STATS_EN adds stats_clr, cnt_exec and
// cnt_skip (saturating counts of executed and suppressed operations).
module alu_cond_unit
  import alu_cond_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic [3:0]           in_flags,
  input  logic [3:0]           in_cond,
  input  logic                 in_flag_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_cond_ex,
`ifdef ALU_COND_STATS_EN
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] cnt_exec,
  output logic [CNT_WIDTH-1:0] cnt_skip,
`endif
  output logic [3:0]           flags_q
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_chk
    $error("CNT_WIDTH must be at least 1");
  end

  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic             out_cond_ex_r;
  logic [3:0]       flags_r;
  logic             cond_ex_s;
  logic             accept_s;

  // Condition is always judged against the flags held before this operation.
  alu_cond_eval u_eval (
    .cond    (in_cond),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  // Single-entry pipeline: accept whenever the slot is empty or draining.
  always_comb begin
    in_ready = ~out_valid_r | out_ready;
    accept_s = in_valid & in_ready;
  end

  // Output register: load on accept, drop valid when drained, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r   <= 1'b0;
      out_result_r  <= {WIDTH{1'b0}};
      out_cond_ex_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      out_result_r  <= in_result;
      out_cond_ex_r <= cond_ex_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

  // Architectural flags: only executed operations that request it write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= 4'b0000;
    end else if (accept_s && cond_ex_s && in_flag_we) begin
      flags_r <= in_flags;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_cond_ex = out_cond_ex_r;
  assign flags_q     = flags_r;

`ifdef ALU_COND_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_exec_r;
  logic [CNT_WIDTH-1:0] cnt_skip_r;

  // Saturating statistics counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_exec_r <= {CNT_WIDTH{1'b0}};
      cnt_skip_r <= {CNT_WIDTH{1'b0}};
    end else if (stats_clr) begin
      cnt_exec_r <= {CNT_WIDTH{1'b0}};
      cnt_skip_r <= {CNT_WIDTH{1'b0}};
    end else if (accept_s) begin
      if (cond_ex_s) begin
        if (cnt_exec_r != CNT_MAX) begin
          cnt_exec_r <= cnt_exec_r + CNT_ONE;
        end
      end else begin
        if (cnt_skip_r != CNT_MAX) begin
          cnt_skip_r <= cnt_skip_r + CNT_ONE;
        end
      end
    end
  end

  assign cnt_exec = cnt_exec_r;
  assign cnt_skip = cnt_skip_r;
`endif

endmodule

// File: tb/tb_alu_cond_unit.sv
// Self-checking bench for alu_cond_unit: reset behaviour, a condition-code
// vector table, directed handshake sequences and randomized traffic against
// a cycle-level reference model. Counter tests apply with ALU_COND_STATS_EN.
module tb_alu_cond_unit;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_result;
  logic [3:0]    in_flags;
  logic [3:0]    in_cond;
  logic          in_flag_we;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_cond_ex;
  logic [3:0]    flags_q;
  logic          stats_clr;
  logic [CW-1:0] cnt_exec;
  logic [CW-1:0] cnt_skip;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_result;
  logic         m_cex;
  logic [3:0]   m_flags;
  int           m_exec;
  int           m_skip;

  alu_cond_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_cond     (in_cond),
    .in_flag_we  (in_flag_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_cond_ex (out_cond_ex),
`ifdef ALU_COND_STATS_EN
    .stats_clr   (stats_clr),
    .cnt_exec    (cnt_exec),
    .cnt_skip    (cnt_skip),
`endif
    .flags_q     (flags_q)
  );

`ifndef ALU_COND_STATS_EN
  assign cnt_exec = '0;
  assign cnt_skip = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM encoding view: even codes test a predicate, odd codes its inverse;
  // code 15 is executed unconditionally.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd15) return 1'b1;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_result = '0; m_cex = 1'b0; m_flags = 4'b0000;
    m_exec = 0; m_skip = 0;
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs.
  task automatic cycle(input logic v, input logic [W-1:0] r, input logic [3:0] f,
                       input logic [3:0] c, input logic we, input logic ordy);
    logic rdy, pass;
    in_valid = v; in_result = r; in_flags = f; in_cond = c; in_flag_we = we;
    out_ready = ordy;
    #2;
    rdy = !m_valid || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (stats_clr) begin
      m_exec = 0; m_skip = 0;
    end
    if (v && rdy) begin
      pass = ref_pass(c, m_flags);
      if (!stats_clr) begin
        if (pass) m_exec = (m_exec < (1 << CW) - 1) ? m_exec + 1 : m_exec;
        else      m_skip = (m_skip < (1 << CW) - 1) ? m_skip + 1 : m_skip;
      end
      m_valid = 1'b1; m_result = r; m_cex = pass;
      if (pass && we) m_flags = f;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid",   {31'd0, out_valid},   {31'd0, m_valid});
    check("out_result",  out_result,           m_result);
    check("out_cond_ex", {31'd0, out_cond_ex}, {31'd0, m_cex});
    check("flags_q",     {28'd0, flags_q},     {28'd0, m_flags});
`ifdef ALU_COND_STATS_EN
    check("cnt_exec", W'(cnt_exec), W'(m_exec));
    check("cnt_skip", W'(cnt_skip), W'(m_skip));
`endif
  endtask

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{4'b0100, 4'd0,  1'b1}, '{4'b0000, 4'd0,  1'b0},
      '{4'b0100, 4'd1,  1'b0}, '{4'b0000, 4'd1,  1'b1},
      '{4'b0010, 4'd2,  1'b1}, '{4'b0000, 4'd3,  1'b1},
      '{4'b0010, 4'd3,  1'b0}, '{4'b1000, 4'd4,  1'b1},
      '{4'b1000, 4'd5,  1'b0}, '{4'b0001, 4'd6,  1'b1},
      '{4'b0001, 4'd7,  1'b0}, '{4'b0010, 4'd8,  1'b1},
      '{4'b0110, 4'd8,  1'b0}, '{4'b0110, 4'd9,  1'b1},
      '{4'b0010, 4'd9,  1'b0}, '{4'b1001, 4'd10, 1'b1},
      '{4'b1000, 4'd10, 1'b0}, '{4'b1001, 4'd11, 1'b0},
      '{4'b0001, 4'd11, 1'b1}, '{4'b1001, 4'd12, 1'b1},
      '{4'b1101, 4'd12, 1'b0}, '{4'b1101, 4'd13, 1'b1},
      '{4'b1001, 4'd13, 1'b0}, '{4'b0000, 4'd14, 1'b1},
      '{4'b0000, 4'd15, 1'b1}
    };

    reset_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = 4'b0000;
    in_cond = 4'd0; in_flag_we = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    model_reset();
    #2;
    check("rst_out_valid",  {31'd0, out_valid},   32'd0);
    check("rst_out_result", out_result,           32'd0);
    check("rst_cond_ex",    {31'd0, out_cond_ex}, 32'd0);
    check("rst_flags",      {28'd0, flags_q},     32'd0);
    #10 reset_n = 1'b1;

    // Reset while an operation is held in a stall.
    cycle(1'b1, 32'hDEAD, 4'b1011, 4'd14, 1'b1, 1'b0);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_flags", {28'd0, flags_q},   32'd0);
    model_reset();
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Flags written by one op are seen by the next.
    cycle(1'b1, 32'd5, 4'b0100, 4'd14, 1'b1, 1'b1);
    check("op1_cond_ex", {31'd0, out_cond_ex}, 32'd1);
    check("op1_flags",   {28'd0, flags_q},     32'h4);
    check("op1_result",  out_result,           32'd5);
    cycle(1'b1, 32'd7, 4'b0000, 4'd0, 1'b0, 1'b1);
    check("op2_eq_cond_ex", {31'd0, out_cond_ex}, 32'd1);

    // Suppressed op must not write flags.
    cycle(1'b1, 32'd9, 4'b1000, 4'd1, 1'b1, 1'b1);
    check("ne_suppressed", {31'd0, out_cond_ex}, 32'd0);
    check("ne_flags_hold", {28'd0, flags_q},     32'h4);

    // Condition table.
    foreach (tbl[i]) begin
      cycle(1'b1, $urandom, tbl[i].flags, 4'd14, 1'b1, 1'b1);
      cycle(1'b1, $urandom, 4'($urandom), tbl[i].cond, 1'b0, 1'b1);
      check($sformatf("tbl%0d_cond%0d", i, tbl[i].cond), {31'd0, out_cond_ex}, {31'd0, tbl[i].exp});
    end

    // Stall for three cycles, then stream eight ops.
    cycle(1'b1, 32'hA0, 4'b0000, 4'd14, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hBB + i, 4'b0000, 4'd14, 1'b0, 1'b0);
      check("stall_ready",  {31'd0, in_ready}, 32'd0);
      check("stall_result", out_result,        32'hA0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h100 + i, 4'b0000, 4'd14, 1'b0, 1'b1);
      check("stream_valid",  {31'd0, out_valid}, 32'd1);
      check("stream_result", out_result,         32'h100 + i);
    end
    cycle(1'b0, 32'd0, 4'b0000, 4'd0, 1'b0, 1'b1);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_COND_STATS_EN
    stats_clr = 1'b1;
    cycle(1'b0, 32'd0, 4'b0000, 4'd0, 1'b0, 1'b1);
    stats_clr = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i), 4'b0000, 4'd14, 1'b0, 1'b1);
    check("cnt_exec_sat", W'(cnt_exec), 32'd3);
    stats_clr = 1'b1;
    cycle(1'b1, 32'd1, 4'b0000, 4'd14, 1'b0, 1'b1);
    stats_clr = 1'b0;
    check("cnt_exec_clr", W'(cnt_exec), 32'd0);
    check("cnt_skip_clr", W'(cnt_skip), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), $urandom, 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
